// File: rtl/cipher_pkg.sv
// cipher_pkg: shared types for the image cipher datapath.
// Holds FSM encoding, word/image constants and the triple bundles.
package cipher_pkg;

  localparam int WORD_W    = 32;
  localparam int IMG_WORDS = 2700;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    FIN     = 3'd4
  } trc_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] val1;
    logic [WORD_W-1:0] val2;
    logic [WORD_W-1:0] val3;
  } triple_t;

  // Tag riding alongside each outstanding read.
  // live=0 marks a padded slot past the image end.
  typedef struct packed {
    logic       live;
    logic       bsel;
    logic [1:0] slot;
  } rd_tag_t;

endpackage

// File: rtl/trc_rd_tracker.sv
// trc_rd_tracker: RD_LAT-deep pipe of read valid + slot tag.
// Ports: clk_i, rst_ni, vld_i/tag_i (issue side), vld_o/tag_o (return side).
module trc_rd_tracker
  import cipher_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    vld_i,
  input  rd_tag_t tag_i,
  output logic    vld_o,
  output rd_tag_t tag_o
);

  logic [RD_LAT-1:0] vld_q;
  rd_tag_t           tag_q [RD_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      tag_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[RD_LAT-1];
  assign tag_o = tag_q[RD_LAT-1];

endmodule

// File: rtl/triple_read_ctrl.sv
// triple_read_ctrl: fetches word triples from a sync-read memory and
// presents them with valid/ready; one bounded pass per start pulse.
// Ports: clk, rst (async, active low), start; mem_ren/mem_addr/mem_rdata;
// val1..val3, out_valid, out_ready, triple_idx; busy, done (sticky).
// Build option: TRIPLE_PREFETCH_EN adds a second (ping-pong) buffer so
// the next triple is fetched while the current one is presented.
module triple_read_ctrl
  import cipher_pkg::*;
#(
  parameter int DATA_W    = WORD_W,
  parameter int ADDR_W    = 12,
  parameter int NUM_WORDS = IMG_WORDS,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] val3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] triple_idx,
  output logic              busy,
  output logic              done
);

`ifdef TRIPLE_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  // Two extra bits so base+slot and base+3 never overflow the compare.
  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0] NW = CW'(NUM_WORDS);

  trc_state_t state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [ADDR_W-1:0] nbase_q, nbase_d;
  logic [ADDR_W-1:0] pbase_q, pbase_d;
  logic [ADDR_W-1:0] pidx_q, pidx_d;
  logic wr_q, wr_d;
  logic rd_q, rd_d;
  logic [1:0] full_q, full_d;
  logic [1:0] pend_q, pend_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] buf_q [2][3];
  logic [DATA_W-1:0] buf_d [2][3];

  logic [CW-1:0] iaddr;
  logic [CW-1:0] nb3;
  logic [CW-1:0] pb3;
  logic          live;
  logic          more;
  logic          xfer;
  logic          wr_nx;
  logic          issuing;
  rd_tag_t       in_tag;
  logic          trk_vld;
  rd_tag_t       trk_tag;

  logic [1:0] full_c;
  logic [1:0] pend_c;
  logic [1:0] launch;
  logic       free_wr;
  logic       free_nx;

  assign issuing = (state_q == ISSUE);
  assign iaddr   = {2'b00, nbase_q} + {{(CW-2){1'b0}}, slot_q};
  assign nb3     = {2'b00, nbase_q} + CW'(3);
  assign pb3     = {2'b00, pbase_q} + CW'(3);
  assign live    = (iaddr < NW);
  assign more    = ({2'b00, nbase_q} < NW);
  assign wr_nx   = wr_q ^ PF;

  // Padded slots are still tracked so they land as zero in order.
  assign mem_ren  = issuing && live;
  assign mem_addr = mem_ren ? iaddr[ADDR_W-1:0] : '0;

  assign in_tag.live = live;
  assign in_tag.bsel = wr_q;
  assign in_tag.slot = slot_q;

  trc_rd_tracker #(
    .RD_LAT(RD_LAT)
  ) u_trk (
    .clk_i (clk),
    .rst_ni(rst),
    .vld_i (issuing),
    .tag_i (in_tag),
    .vld_o (trk_vld),
    .tag_o (trk_tag)
  );

  assign out_valid  = full_q[rd_q];
  assign val1       = buf_q[rd_q][0];
  assign val2       = buf_q[rd_q][1];
  assign val3       = buf_q[rd_q][2];
  assign triple_idx = pidx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign xfer       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    nbase_d = nbase_q;
    pbase_d = pbase_q;
    pidx_d  = pidx_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    buf_d   = buf_q;
    full_c  = full_q;
    pend_c  = pend_q;
    launch  = '0;

    if (trk_vld) begin
      buf_d[trk_tag.bsel][trk_tag.slot] =
        trk_tag.live ? mem_rdata : '0;
      if (trk_tag.slot == 2'd2) begin
        full_c[trk_tag.bsel] = 1'b1;
        pend_c[trk_tag.bsel] = 1'b0;
      end
    end

    if (xfer) begin
      full_c[rd_q] = 1'b0;
      rd_d = rd_q ^ PF;
      if (pb3 < NW) begin
        pbase_d = pbase_q + ADDR_W'(3);
        pidx_d  = pidx_q + ADDR_W'(1);
      end
    end

    // A buffer is free once nothing is held in it or headed to it.
    free_wr = !pend_c[wr_q] && !full_c[wr_q];
    free_nx = !pend_c[wr_nx] && !full_c[wr_nx];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          slot_d  = 2'd0;
          nbase_d = '0;
          pbase_d = '0;
          pidx_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          launch[wr_q] = 1'b1;
        end
      end
      ISSUE: begin
        slot_d = slot_q + 2'd1;
        if (slot_q == 2'd2) begin
          slot_d  = 2'd0;
          nbase_d = nb3[ADDR_W-1:0];
          wr_d    = wr_nx;
          if ((nb3 < NW) && free_nx) begin
            launch[wr_nx] = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN, PRESENT: begin
        if (more && free_wr) begin
          state_d = ISSUE;
          slot_d  = 2'd0;
          launch[wr_q] = 1'b1;
        end else if (pend_c != 2'b00) begin
          state_d = DRAIN;
        end else if ((full_c != 2'b00) || more) begin
          state_d = PRESENT;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pend_d = pend_c | launch;
    full_d = full_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      nbase_q <= '0;
      pbase_q <= '0;
      pidx_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      full_q  <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 3; j++) begin
          buf_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      nbase_q <= nbase_d;
      pbase_q <= pbase_d;
      pidx_q  <= pidx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_triple_read_ctrl.sv
// tb_triple_read_ctrl: scoreboard bench for triple_read_ctrl.
// Three instances: (RD_LAT=1,NW=6), (RD_LAT=1,NW=7), (RD_LAT=3,NW=2700).
module tb_triple_read_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start     [NI];
  logic        out_ready [NI];
  logic        mem_ren   [NI];
  logic [11:0] mem_addr  [NI];
  logic [31:0] mem_rdata [NI];
  logic [31:0] v1        [NI];
  logic [31:0] v2        [NI];
  logic [31:0] v3        [NI];
  logic        out_valid [NI];
  logic [11:0] tidx      [NI];
  logic        busy      [NI];
  logic        done      [NI];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nxfer [NI] = '{default: 0};
  int last_xfer [NI] = '{default: 0};

  typedef struct {
    int          inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [11:0] k;
  } exp_t;

  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RL = (g == 2) ? 3 : 1;
    localparam int NW = (g == 0) ? 6 : ((g == 1) ? 7 : 2700);
    logic [31:0] st [RL];

    // Word i holds 0x100+i; idle cycles return junk.
    always @(posedge clk) begin
      st[0] <= mem_ren[g] ? (32'h100 + 32'(mem_addr[g])) : 32'hDEAD_BEEF;
      for (int i = 1; i < RL; i++) st[i] <= st[i-1];
    end
    assign mem_rdata[g] = st[RL-1];

    triple_read_ctrl #(
      .DATA_W(32), .ADDR_W(12), .NUM_WORDS(NW), .RD_LAT(RL)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]),
      .mem_ren(mem_ren[g]), .mem_addr(mem_addr[g]),
      .mem_rdata(mem_rdata[g]),
      .val1(v1[g]), .val2(v2[g]), .val3(v3[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .triple_idx(tidx[g]), .busy(busy[g]), .done(done[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c,
                      input logic [11:0] k);
    exp_t e;
    e.inst = i; e.a = a; e.b = b; e.c = c; e.k = k;
    sb.push_back(e);
  endtask

  // Monitor: every accepted triple is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (out_valid[i] && out_ready[i]) begin
        nxfer[i]++;
        last_xfer[i] = cyc + 1;
        if (sb.size() == 0) begin
          chk("sb_unexpected_xfer", i, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_inst", i, e.inst);
          chk("sb_val1", v1[i], e.a);
          chk("sb_val2", v2[i], e.b);
          chk("sb_val3", v3[i], e.c);
          chk("sb_idx", {20'd0, tidx[i]}, {20'd0, e.k});
        end
      end
    end
    if (busy[1]) chk("pad_addr_lt7", 32'(mem_addr[1] < 12'd7), 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done[i] && n < budget) begin
      step();
      n++;
    end
    chk("done_reached", done[i], 1);
  endtask

  task automatic wait_valid(input int i, input int budget);
    int n = 0;
    while (!out_valid[i] && n < budget) begin
      step();
      n++;
    end
    chk("valid_reached", out_valid[i], 1);
  endtask

  task automatic chk_zero(input int i);
    chk("z_mem_ren", mem_ren[i], 0);
    chk("z_mem_addr", {20'd0, mem_addr[i]}, 0);
    chk("z_val1", v1[i], 0);
    chk("z_val2", v2[i], 0);
    chk("z_val3", v3[i], 0);
    chk("z_out_valid", out_valid[i], 0);
    chk("z_idx", {20'd0, tidx[i]}, 0);
    chk("z_busy", busy[i], 0);
    chk("z_done", done[i], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      out_ready[i] = 1'b0;
    end
    #2 rst = 1'b0;
    step();
    step();
    for (int i = 0; i < NI; i++) chk_zero(i);
    rst = 1'b1;
    step();

    // Basic pass, NW=6, RD_LAT=1, ready always high.
    out_ready[0] = 1'b1;
    push(0, 32'h100, 32'h101, 32'h102, 12'd0);
    push(0, 32'h103, 32'h104, 32'h105, 12'd1);
    pulse_start(0);
    chk("b_busy", busy[0], 1);
    chk("b_ren0", mem_ren[0], 1);
    chk("b_addr0", {20'd0, mem_addr[0]}, 0);
    chk("b_lat_e0", out_valid[0], 0);
    for (int n = 1; n <= 4; n++) begin
      step();
      chk($sformatf("b_lat_e%0d", n), out_valid[0], 32'(n == 4));
      if (n < 3) chk($sformatf("b_addr%0d", n), {20'd0, mem_addr[0]}, n);
      if (n == 3) chk("b_ren_drain", mem_ren[0], 0);
    end
    wait_done(0, 60);
    chk("b_done_timing", cyc, last_xfer[0] + 1);
    chk("b_busy_end", busy[0], 0);
    chk("b_nxfer", nxfer[0], 2);

    // Backpressure, then start during FIN.
    out_ready[0] = 1'b0;
    push(0, 32'h100, 32'h101, 32'h102, 12'd0);
    push(0, 32'h103, 32'h104, 32'h105, 12'd1);
    pulse_start(0);
    chk("bp_done_clr", done[0], 0);
    wait_valid(0, 20);
    for (int n = 0; n < 10; n++) begin
      chk("bp_valid", out_valid[0], 1);
      chk("bp_v1", v1[0], 32'h100);
      chk("bp_v2", v2[0], 32'h101);
      chk("bp_v3", v3[0], 32'h102);
      chk("bp_ren", mem_ren[0], 0);
      step();
    end
    out_ready[0] = 1'b1;
    step();
    chk("bp_xfer1", nxfer[0], 3);
    chk("bp_valid_drop", out_valid[0], 0);
    out_ready[0] = 1'b0;
    wait_valid(0, 20);
    chk("bp_idx1", {20'd0, tidx[0]}, 1);
    out_ready[0] = 1'b1;
    step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    out_ready[0] = 1'b0;
    chk("fin_done", done[0], 1);
    chk("fin_busy", busy[0], 0);
    step();
    step();
    chk("fin_start_ign", busy[0], 0);
    chk("fin_ren", mem_ren[0], 0);

    // Padding, NW=7.
    out_ready[1] = 1'b1;
    push(1, 32'h100, 32'h101, 32'h102, 12'd0);
    push(1, 32'h103, 32'h104, 32'h105, 12'd1);
    push(1, 32'h106, 32'h0, 32'h0, 12'd2);
    pulse_start(1);
    wait_done(1, 80);
    chk("pad_nxfer", nxfer[1], 3);

    // Reset while the second triple is being issued.
    push(1, 32'h100, 32'h101, 32'h102, 12'd0);
    pulse_start(1);
    begin
      int n = 0;
      while (!(mem_ren[1] && tidx[1] == 12'd1) && n < 30) begin
        step();
        n++;
      end
      chk("rst_reached_issue", 32'(mem_ren[1] && tidx[1] == 12'd1), 1);
    end
    rst = 1'b0;
    #1;
    chk_zero(1);
    step();
    rst = 1'b1;
    step();
    push(1, 32'h100, 32'h101, 32'h102, 12'd0);
    push(1, 32'h103, 32'h104, 32'h105, 12'd1);
    push(1, 32'h106, 32'h0, 32'h0, 12'd2);
    pulse_start(1);
    wait_done(1, 80);
    chk("rst_nxfer", nxfer[1], 7);

    // Full default pass, RD_LAT=3, extra start while busy.
    out_ready[2] = 1'b1;
    for (int k = 0; k < 900; k++) begin
      push(2, 32'h100 + 32'(3 * k), 32'h101 + 32'(3 * k),
           32'h102 + 32'(3 * k), 12'(k));
    end
    pulse_start(2);
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("l3_lat_e%0d", n), out_valid[2], 32'(n == 6));
      if (n == 2) start[2] = 1'b1;
      if (n == 3) start[2] = 1'b0;
    end
    wait_done(2, 7600);
    chk("l3_nxfer", nxfer[2], 900);
    chk("l3_idx", {20'd0, tidx[2]}, 899);
    chk("l3_busy", busy[2], 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
